dm_responder: RTL and testbench

//  Data-memory responder: the slave end of the multicycle controller's MEM-stage access (mem_write_en, dm_sel).

---
 rtl/dm_responder_pkg.sv | 27 ++
 rtl/dm_lane_ctrl.sv | 60 ++++++
 rtl/dm_responder.sv | 161 ++++++++++++++++
 tb/tb_dm_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - Access-size codes presented on dm_sel by the MEM stage.
//   - FSM state encodings, exported on the debug state port.
//   - Sign-extension helpers used by the lane controller.
// Optional feature macro: DM_HALFWORD_EN (half-word accesses legal when defined).
package dm_responder_pkg;

  // Access size codes; 2'b11 is reserved and always rejected.
  localparam logic [1:0] DM_WORD = 2'b00;
  localparam logic [1:0] DM_BYTE = 2'b01;
  localparam logic [1:0] DM_HALF = 2'b10;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'b00,
    DMR_WAIT = 2'b01,
    DMR_ACK  = 2'b10
  } dmr_state_e;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/dm_lane_ctrl.sv
// Combinational lane steering for one memory word (little-endian).
// Ports:
//   i_old_word    current contents of the addressed word
//   i_wdata       store data (byte/half stores use the low bits)
//   i_dm_sel      access size code
//   i_addr_lo     byte address bits [1:0]
//   o_store_word  word to write back (read-modify-write merge)
//   o_load_value  load result, sign-extended for sub-word sizes
//   o_align_err   access is misaligned or uses an unsupported size code
// Optional feature macro: DM_HALFWORD_EN builds the half-lane path; without
// it DM_HALF is reported as an error like the reserved code.
module dm_lane_ctrl
  import dm_responder_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_dm_sel,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_value,
  output logic        o_align_err
);

  // Bit offset of the selected byte lane.
  logic [4:0] w_byte_sh;
  assign w_byte_sh = {i_addr_lo, 3'b000};

`ifdef DM_HALFWORD_EN
  // Bit offset of the selected half lane (addr[1] picks upper/lower half).
  logic [4:0] w_half_sh;
  assign w_half_sh = {i_addr_lo[1], 4'b0000};
`endif

  always_comb begin
    o_store_word = i_old_word;
    o_load_value = i_old_word;
    o_align_err  = 1'b0;
    case (i_dm_sel)
      DM_WORD: begin
        o_store_word = i_wdata;
        o_align_err  = (i_addr_lo != 2'b00);
      end
      DM_BYTE: begin
        o_store_word[w_byte_sh +: 8] = i_wdata[7:0];
        o_load_value = sext8(i_old_word[w_byte_sh +: 8]);
      end
`ifdef DM_HALFWORD_EN
      DM_HALF: begin
        o_store_word[w_half_sh +: 16] = i_wdata[15:0];
        o_load_value = sext16(i_old_word[w_half_sh +: 16]);
        o_align_err  = i_addr_lo[0];
      end
`else
      DM_HALF: o_align_err = 1'b1;
`endif
      default: o_align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: slave end of the MEM-stage load/store access.
// Accepts one request at a time, waits LATENCY cycles (counted from the
// cycle the request is presented to the ack cycle), commits the access to
// an internal word array, then pulses ack with read data and an error flag.
// Ports:
//   i_clk, i_reset   clock; asynchronous active-high reset
//   i_req            request strobe, sampled only in IDLE
//   i_we             1 = store, 0 = load
//   i_dm_sel         access size (DM_WORD / DM_BYTE / DM_HALF)
//   i_addr           byte address; word index = addr[31:2]
//   i_wdata          store data
//   o_rdata          last successful load result (held between loads)
//   o_ack            one-cycle completion pulse
//   o_busy           high from the accept cycle through the ack cycle
//   o_addr_err       valid with ack: access rejected, nothing written
//   o_dbg_state      current FSM state (dmr_state_e encoding)
// Handshake: a request is taken when i_req is high in an IDLE cycle; the
// command fields are latched at that edge and later input changes are
// ignored. Requests while busy are dropped, not queued.
// Optional feature macro: DM_HALFWORD_EN (half-word accesses).
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_dm_sel,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  output logic        o_addr_err,
  output logic [1:0]  o_dbg_state
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmr_state_e  r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic        r_we;
  logic [1:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_addr_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_commit;
  logic        w_we;
  logic [1:0]  w_sel;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [IDX_W-1:0] w_idx;
  logic        w_range_err;
  logic        w_lane_err;
  logic        w_err;
  logic [31:0] w_old_word;
  logic [31:0] w_store_word;
  logic [31:0] w_load_value;

  assign w_accept = (r_state == DMR_IDLE) && i_req;

  // With LATENCY=1 the access commits on the accept edge itself, so the
  // command comes straight from the inputs while IDLE; otherwise it comes
  // from the latched copy.
  assign w_we    = (r_state == DMR_IDLE) ? i_we     : r_we;
  assign w_sel   = (r_state == DMR_IDLE) ? i_dm_sel : r_sel;
  assign w_addr  = (r_state == DMR_IDLE) ? i_addr   : r_addr;
  assign w_wdata = (r_state == DMR_IDLE) ? i_wdata  : r_wdata;

  // Commit on the edge where the wait counter reaches zero.
  assign w_commit = (w_accept && (LATENCY == 1)) ||
                    ((r_state == DMR_WAIT) && (r_cnt <= 4'd1));

  assign w_idx       = w_addr[IDX_W+1:2];
  assign w_range_err = (w_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_err       = w_range_err || w_lane_err;
  assign w_old_word  = r_mem[w_idx];

  dm_lane_ctrl u_lane (
    .i_old_word   (w_old_word),
    .i_wdata      (w_wdata),
    .i_dm_sel     (w_sel),
    .i_addr_lo    (w_addr[1:0]),
    .o_store_word (w_store_word),
    .o_load_value (w_load_value),
    .o_align_err  (w_lane_err)
  );

  // Next-state / counter logic.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      DMR_IDLE: begin
        if (i_req) begin
          w_cnt_nx   = LAT_M1;
          w_state_nx = (LATENCY == 1) ? DMR_ACK : DMR_WAIT;
        end
      end
      DMR_WAIT: begin
        w_cnt_nx = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nx   = 4'd0;
          w_state_nx = DMR_ACK;
        end
      end
      DMR_ACK:  w_state_nx = DMR_IDLE;
      default:  w_state_nx = DMR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= DMR_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_sel      <= DM_WORD;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_we    <= i_we;
        r_sel   <= i_dm_sel;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (w_commit && !w_we && !w_err) begin
        r_rdata <= w_load_value;
      end
      // Only ever set for the single ack cycle that follows a commit.
      r_addr_err <= w_commit && w_err;
    end
  end

  // Array contents survive reset; an aborted access never reaches a commit
  // edge because reset forces the FSM back to IDLE.
  always_ff @(posedge i_clk) begin
    if (w_commit && w_we && !w_err) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

  assign o_rdata     = r_rdata;
  assign o_ack       = (r_state == DMR_ACK);
  assign o_busy      = (r_state != DMR_IDLE) || (i_req && !i_reset);
  assign o_addr_err  = r_addr_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;
  import dm_responder_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  dm_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        addr_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = 32'd0;

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req       (req),
    .i_we        (we),
    .i_dm_sel    (dm_sel),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .o_ack       (ack),
    .o_busy      (busy),
    .o_addr_err  (addr_err),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: called just after a posedge; presents one request, waits for ack
  // (bounded), returns the flags seen in the ack cycle and the cycle number
  // of the ack counting the request cycle as 1. Returns just after a posedge.
  task automatic access(input logic a_we, input logic [1:0] a_sel,
                        input logic [31:0] a_addr, input logic [31:0] a_wdata,
                        output logic a_err, output logic [31:0] a_rd,
                        output int a_lat);
    req = 1'b1; we = a_we; dm_sel = a_sel; addr = a_addr; wdata = a_wdata;
    a_err = 1'b0; a_rd = 32'd0; a_lat = 1;
    @(posedge clk); #1;
    req = 1'b0;
    while (a_lat < 20) begin
      @(negedge clk);
      a_lat++;
      if (ack) begin
        a_err = addr_err;
        a_rd  = rdata;
        break;
      end
    end
    if (a_lat >= 20) begin
      checks++; errors++;
      $display("FAIL ack_timeout addr=%h: no ack within 20 cycles", a_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", addr_err); end
    checks++; if (dbg_state !== DMR_IDLE) begin errors++; $display("FAIL rst_state got %0d want 0", dbg_state); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL post_rst_idle busy=%b ack=%b want 0 0", busy, ack); end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic e; logic [31:0] r; int l;
    req = 1'b1; we = 1'b1; dm_sel = DM_WORD; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL sw_cyc1 busy=%b ack=%b want 1 0", busy, ack); end
    @(posedge clk); #1;
    req = 1'b0; wdata = 32'h0; addr = 32'h0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL sw_cyc2 busy=%b ack=%b want 1 0", busy, ack); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ack !== 1'b1 || addr_err !== 1'b0) begin errors++; $display("FAIL sw_cyc3 busy=%b ack=%b err=%b want 1 1 0", busy, ack, addr_err); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL sw_rdata got %h want 0", rdata); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL sw_cyc4 busy=%b ack=%b want 0 0", busy, ack); end
    @(posedge clk); #1;
    access(1'b0, DM_WORD, 32'h10, 32'h0, e, r, l);
    exp_rd = 32'hDEADBEEF;
    checks++; if (r !== exp_rd || e !== 1'b0) begin errors++; $display("FAIL lw_10 got %h err=%b want %h 0", r, e, exp_rd); end
    checks++; if (l !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", l); end
  endtask

  task automatic test_byte();
    logic e; logic [31:0] r; int l;
    access(1'b1, DM_BYTE, 32'h11, 32'h000000F0, e, r, l);
    checks++; if (e !== 1'b0 || r !== exp_rd) begin errors++; $display("FAIL sb_11 err=%b rdata=%h want 0 %h", e, r, exp_rd); end
    access(1'b0, DM_WORD, 32'h10, 32'h0, e, r, l);
    checks++; if (r !== 32'hDEADF0EF) begin errors++; $display("FAIL sb_merge got %h want deadf0ef", r); end
    access(1'b0, DM_BYTE, 32'h11, 32'h0, e, r, l);
    checks++; if (r !== 32'hFFFFFFF0 || e !== 1'b0) begin errors++; $display("FAIL lb_11 got %h err=%b want fffffff0 0", r, e); end
    access(1'b0, DM_BYTE, 32'h10, 32'h0, e, r, l);
    checks++; if (r !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_10 got %h want ffffffef", r); end
    access(1'b0, DM_BYTE, 32'h13, 32'h0, e, r, l);
    checks++; if (r !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_13 got %h want ffffffde", r); end
    access(1'b1, DM_BYTE, 32'h13, 32'hABCDEF12, e, r, l);
    access(1'b0, DM_BYTE, 32'h13, 32'h0, e, r, l);
    checks++; if (r !== 32'h00000012) begin errors++; $display("FAIL lb_13_pos got %h want 00000012", r); end
    access(1'b0, DM_WORD, 32'h10, 32'h0, e, r, l);
    exp_rd = 32'h12ADF0EF;
    checks++; if (r !== exp_rd) begin errors++; $display("FAIL sb_13_merge got %h want %h", r, exp_rd); end
  endtask

  task automatic test_errors();
    logic e; logic [31:0] r; int l;
    access(1'b1, DM_WORD, 32'h0, 32'hCAFEF00D, e, r, l);
    access(1'b0, DM_WORD, 32'h12, 32'h0, e, r, l);
    checks++; if (e !== 1'b1 || r !== exp_rd) begin errors++; $display("FAIL lw_misalign err=%b rdata=%h want 1 %h", e, r, exp_rd); end
    @(negedge clk);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", addr_err); end
    @(posedge clk); #1;
    access(1'b1, DM_WORD, 32'(4 * DEPTH), 32'h00000055, e, r, l);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sw_range err=%b want 1", e); end
    access(1'b1, DM_WORD, 32'h12, 32'h00000077, e, r, l);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sw_misalign err=%b want 1", e); end
    access(1'b0, 2'b11, 32'h10, 32'h0, e, r, l);
    checks++; if (e !== 1'b1 || r !== exp_rd) begin errors++; $display("FAIL rsvd_sel err=%b rdata=%h want 1 %h", e, r, exp_rd); end
    access(1'b0, DM_WORD, 32'h0, 32'h0, e, r, l);
    checks++; if (r !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL range_nowrite got %h want cafef00d", r); end
    access(1'b0, DM_WORD, 32'h10, 32'h0, e, r, l);
    checks++; if (r !== 32'h12ADF0EF) begin errors++; $display("FAIL misalign_nowrite got %h want 12adf0ef", r); end
    exp_rd = 32'h12ADF0EF;
  endtask

  task automatic test_back_to_back();
    logic e; logic [31:0] r; int l;
    logic [8:0] pat;
    pat = 9'd0;
    req = 1'b1; we = 1'b1; dm_sel = DM_WORD; addr = 32'h30; wdata = 32'h11111111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      pat[c] = ack;
      @(posedge clk); #1;
      if (c == 0) begin addr = 32'h34; wdata = 32'h22222222; end
      if (c == 8) req = 1'b0;
    end
    checks++; if (pat !== 9'b100100100) begin errors++; $display("FAIL b2b_acks got %b want 100100100", pat); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b want 0", busy); end
    @(posedge clk); #1;
    access(1'b0, DM_WORD, 32'h30, 32'h0, e, r, l);
    checks++; if (r !== 32'h11111111) begin errors++; $display("FAIL b2b_latched got %h want 11111111", r); end
    access(1'b0, DM_WORD, 32'h34, 32'h0, e, r, l);
    checks++; if (r !== 32'h22222222) begin errors++; $display("FAIL b2b_second got %h want 22222222", r); end
  endtask

  task automatic test_reset_abort();
    logic e; logic [31:0] r; int l;
    access(1'b1, DM_WORD, 32'h20, 32'hAAAA5555, e, r, l);
    req = 1'b1; we = 1'b1; dm_sel = DM_WORD; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (rdata !== 32'd0 || ack !== 1'b0 || busy !== 1'b0 || addr_err !== 1'b0)
      begin errors++; $display("FAIL abort_outputs rdata=%h ack=%b busy=%b err=%b want 0", rdata, ack, busy, addr_err); end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    access(1'b0, DM_WORD, 32'h20, 32'h0, e, r, l);
    checks++; if (r !== 32'hAAAA5555) begin errors++; $display("FAIL abort_nowrite got %h want aaaa5555", r); end
  endtask

  task automatic test_half();
    logic e; logic [31:0] r; int l;
    access(1'b1, DM_HALF, 32'h22, 32'h00008001, e, r, l);
`ifdef DM_HALFWORD_EN
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sh_22 err=%b want 0", e); end
    access(1'b0, DM_HALF, 32'h22, 32'h0, e, r, l);
    checks++; if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lh_22 got %h want ffff8001", r); end
    access(1'b0, DM_HALF, 32'h21, 32'h0, e, r, l);
    checks++; if (e !== 1'b1 || r !== 32'hFFFF8001) begin errors++; $display("FAIL lh_21 err=%b rdata=%h want 1 ffff8001", e, r); end
    access(1'b0, DM_WORD, 32'h20, 32'h0, e, r, l);
    checks++; if (r !== 32'h80015555) begin errors++; $display("FAIL sh_merge got %h want 80015555", r); end
`else
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sh_disabled err=%b want 1", e); end
    access(1'b0, DM_WORD, 32'h20, 32'h0, e, r, l);
    checks++; if (r !== 32'hAAAA5555) begin errors++; $display("FAIL sh_nowrite got %h want aaaa5555", r); end
`endif
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; dm_sel = DM_WORD; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_word();
    test_byte();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_half();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
